fft_buf_reader: RTL
===================

// Module: fft_buf_reader
// PURPOSE
//  Read side of the 64-point ping-pong FFT input buffer. The writer fills bank 0/1 in bit-reversed
//  address order and signals completion per frame. This block reads each completed bank in natural
//  order (0..N-1), muxes the two bank read ports, and streams one frame per bank to the FFT core.
//  It also flags overrun when the writer completes a bank that has not yet been fully read.
// PARAMETERS
//  N_LOG2  6   log2 frame length; FRAME_LEN = 2**N_LOG2 = 64
//  DW      32  sample width (16b I | 16b Q)
//  RD_LAT  1   memory read latency in cycles (rd_en -> rdataX valid), >=1
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       reset, asynchronous, active-high
//  wr_done    in   1       1-cycle pulse: writer finished a frame into bank wr_bank
//  wr_bank    in   1       bank just completed (0/1), qualified by wr_done
//  out_ready  in   1       downstream permits issue of a new read this cycle
//  rdata0     in   DW      bank 0 read data, RD_LAT after rd_en
//  rdata1     in   DW      bank 1 read data, RD_LAT after rd_en
//  rd_en      out  1       read strobe, combinational: (state==READ) && out_ready
//  rd_bank    out  1       bank addressed by rd_en/rd_addr
//  rd_addr    out  N_LOG2  natural-order read address (= frame counter)
//  dout       out  DW      registered sample to FFT
//  dout_valid out  1       dout valid
//  sof / eof  out  1       with dout_valid: sample index 0 / FRAME_LEN-1
//  busy       out  1       state==READ
//  bank_full  out  2       per-bank "frame ready, not yet fully read"
//  overflow   out  1       sticky overrun flag, cleared only by reset
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, next_bank=0, bank_full=0, overflow=0, all pipe regs 0; all outputs 0.
//  - wr_done: bank_full[wr_bank] set next cycle. If bank_full[wr_bank] already 1 (incl. bank being
//    read) -> overflow<=1, bank_full stays 1, read in progress continues undisturbed.
//  - FSM IDLE: if bank_full[next_bank] -> READ, cnt<=0. Banks served strictly alternately via
//    next_bank; a full non-next bank waits (no reordering).
//  - FSM READ: each cycle with out_ready: rd_en=1, rd_addr=cnt, rd_bank=next_bank, cnt<=cnt+1.
//    out_ready low: rd_en=0, cnt holds (stall, no bubble-fill). Downstream must accept every
//    dout_valid; out_ready only throttles issue.
//  - Last issue (cnt==FRAME_LEN-1 && rd_en): cnt wraps to 0, bank_full[next_bank]<=0, next_bank
//    toggles. If bank_full of the other bank is 1 (or set this cycle) -> stay READ (back-to-back,
//    zero gap); else -> IDLE.
//  - Same-cycle wr_done for the bank whose last read issues: counts as overflow; bank_full remains 1.
//  - Latency: wr_done@t -> bank_full@t+1 -> first rd_en@t+1 combinationally if state reaches READ
//    at t+1 (IDLE decision uses registered bank_full, so first rd_en at t+2).
//    rd_en@k -> dout_valid@k+RD_LAT+1; dout = registered mux(rdata0/rdata1) by bank delayed RD_LAT.
//  - sof/eof/bank travel in the same RD_LAT+1 pipe as valid; sof=(rd_addr==0), eof=(rd_addr==FRAME_LEN-1).
//  - Reset mid-frame: pipe flushed, partial frame discarded, no eof emitted.
// STRUCTURE
//  - Shared pkg: N_LOG2, FRAME_LEN, DW, state encoding IDLE=1'b0 / READ=1'b1.
//  - One sub-module: rd_pipe (param depth RD_LAT, width 4: valid,sof,eof,bank) shift-register
//    with async active-high reset; dout register + bank mux stay in top level.
// TESTING
//  1 wr_done bank0, out_ready=1 -> rd_en from t+2 for 64 cycles, addr 0..63, dout_valid
//    64 cycles with sof on first/eof on last, dout==rdata0; bank_full=00 after.
//  2 bank0 then bank1 done 10 cycles apart, ready=1 -> 128 contiguous rd_en, rd_bank 0 then 1, no gap.
//  3 ready toggling 1/0 every cycle during frame -> 64 rd_en over 127 cycles, addrs monotonic,
//    64 dout_valid, eof once.
//  4 wr_done bank0 twice before read completes -> overflow=1 sticky; frame still read 0..63.
//  5 wr_done bank1 only (next_bank=0) -> stays IDLE, bank_full=10, no rd_en.
//  6 rst_n pulsed at addr 30 -> all outputs 0 next edge; new wr_done bank0 reads from addr 0.

Source files
------------

// File: rtl/fft_buf_reader_pkg.sv
// Shared constants and types for the FFT input-buffer read side.
package fft_buf_reader_pkg;

  localparam int unsigned N_LOG2    = 6;
  localparam int unsigned FRAME_LEN = 2 ** N_LOG2;
  localparam int unsigned DW        = 32;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_e;

  // Sideband that travels alongside each read through the memory latency.
  typedef struct packed {
    logic valid;
    logic sof;
    logic eof;
    logic bank;
  } rd_tag_t;

  localparam int unsigned TAG_W = $bits(rd_tag_t);

endpackage

// File: rtl/fft_buf_reader_rd_pipe.sv
// Fixed-depth shift register that delays read sideband to line up with memory data.
//   clk, rst_n : clock, asynchronous active-high reset
//   d          : tag launched with the read strobe
//   q          : tag DEPTH cycles later
module fft_buf_reader_rd_pipe
  import fft_buf_reader_pkg::*;
#(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = TAG_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr_q [DEPTH];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/fft_buf_reader.sv
// Read side of the ping-pong FFT input buffer: drains each completed bank in natural
// order, strictly alternating banks, and streams one frame per bank to the FFT core.
//   clk, rst_n        : clock, asynchronous active-high reset
//   wr_done, wr_bank  : writer finished a frame into wr_bank (1-cycle pulse)
//   out_ready         : permits issue of a new read this cycle
//   rdata0, rdata1    : bank read data, RD_LAT cycles after rd_en
//   rd_en             : combinational read strobe
//   rd_bank, rd_addr  : bank and natural-order address for the read
//   dout, dout_valid  : registered sample to the FFT core
//   sof, eof          : first / last sample of a frame, qualified by dout_valid
//   busy              : a frame is being read
//   bank_full         : per-bank frame ready and not yet fully read
//   overflow          : sticky overrun flag
module fft_buf_reader
  import fft_buf_reader_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_done,
  input  logic              wr_bank,
  input  logic              out_ready,
  input  logic [DW-1:0]     rdata0,
  input  logic [DW-1:0]     rdata1,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [N_LOG2-1:0] rd_addr,
  output logic [DW-1:0]     dout,
  output logic              dout_valid,
  output logic              sof,
  output logic              eof,
  output logic              busy,
  output logic [1:0]        bank_full,
  output logic              overflow
);

  state_e            state_q, state_d;
  logic [N_LOG2-1:0] cnt_q, cnt_d;
  logic              next_bank_q, next_bank_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic              overflow_q, overflow_d;
  logic              last_issue_c;
  rd_tag_t           tag_in, tag_out;

  assign rd_en        = (state_q == READ) && out_ready;
  assign rd_addr      = cnt_q;
  assign rd_bank      = next_bank_q;
  assign busy         = (state_q == READ);
  assign bank_full    = bank_full_q;
  assign overflow     = overflow_q;
  assign last_issue_c = rd_en && (cnt_q == N_LOG2'(FRAME_LEN - 1));

  // Next-state, counter and bank bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    next_bank_d = next_bank_q;
    bank_full_d = bank_full_q;
    overflow_d  = overflow_q;

    // Clear before set: a same-cycle wr_done on the draining bank keeps it full.
    if (last_issue_c) bank_full_d[next_bank_q] = 1'b0;
    if (wr_done) begin
      if (bank_full_q[wr_bank]) overflow_d = 1'b1;
      bank_full_d[wr_bank] = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bank_full_q[next_bank_q]) begin
          state_d = READ;
          cnt_d   = '0;
        end
      end
      READ: begin
        if (rd_en) begin
          cnt_d = cnt_q + N_LOG2'(1);
          if (last_issue_c) begin
            next_bank_d = ~next_bank_q;
            // Zero-gap handover when the other bank is (or just became) full.
            if (!bank_full_d[~next_bank_q]) state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      next_bank_q <= 1'b0;
      bank_full_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      next_bank_q <= next_bank_d;
      bank_full_q <= bank_full_d;
      overflow_q  <= overflow_d;
    end
  end

  // Tag launched with each read; sof/eof are only meaningful with valid.
  always_comb begin
    tag_in.valid = rd_en;
    tag_in.sof   = rd_en && (cnt_q == '0);
    tag_in.eof   = last_issue_c;
    tag_in.bank  = next_bank_q;
  end

  fft_buf_reader_rd_pipe #(
    .DEPTH (RD_LAT),
    .W     (TAG_W)
  ) u_rd_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (tag_in),
    .q     (tag_out)
  );

  // Output register: capture the bank selected when the read was issued.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
    end else begin
      dout_valid <= tag_out.valid;
      sof        <= tag_out.sof;
      eof        <= tag_out.eof;
      if (tag_out.valid) dout <= tag_out.bank ? rdata1 : rdata0;
    end
  end

endmodule
